// File: rtl/bram_port_arbiter_pkg.sv
// Shared defaults and helpers for the BlockRam port arbiter.
package bram_port_arbiter_pkg;

   localparam int ADDR_W_DEF    = 16;
   localparam int DATA_W_DEF    = 18;
   localparam int MAX_BURST_DEF = 4;
   localparam int BURST_CNT_W   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } own_state_e;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// Combinational round-robin select: first eligible requester at or after ptr_i.
module bram_port_arbiter_rr_picker #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   input  logic [NREQ-1:0] mask_i,
   output logic [NREQ-1:0] gnt_o
);

   logic [NREQ-1:0] elig;
   logic            found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      elig  = req_i & mask_i;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && elig[j] && (j == ((int'(ptr_i) + k) % NREQ))) begin
               gnt_o[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with burst allowance sharing one synchronous BlockRam port.
//
// state   | meaning
// ST_IDLE | no command issued last cycle, no owner, burst count clear
// ST_OWN  | cmd_idx_q issued a command last cycle and owns the port
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int NREQ      = 3,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                     clka,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*ADDR_W-1:0]   addr,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_din,
   output logic                     mem_we,
   input  logic [DATA_W-1:0]        mem_dout
);

   localparam int IW = idx_width(NREQ);
   localparam int CW = BURST_CNT_W;
   localparam logic [CW-1:0]   MAXB  = CW'(MAX_BURST);
   localparam logic [CW-1:0]   ONE_C = 1;
   localparam logic [IW-1:0]   ONE_I = 1;
   localparam logic [IW-1:0]   LAST  = IW'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE_N = 1;

   own_state_e        st_q, st_d;
   logic [IW-1:0]     cmd_idx_q, cmd_idx_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;
   logic              rd_vld_q;
   logic [IW-1:0]     rd_idx_q;

   logic [NREQ-1:0]   owner_oh, pick_mask, pick_oh, win_oh;
   logic              others_pend, at_limit, keep, any_win;
   logic [IW-1:0]     win_idx;

   always_comb begin
      owner_oh = '0;
      if (st_q == ST_OWN) owner_oh = ONE_N << cmd_idx_q;
      others_pend = |(req & ~owner_oh);
      at_limit    = (cnt_q >= MAXB);
      keep        = (|(req & owner_oh)) && (!at_limit || !others_pend);
      // An exhausted owner sits out one round only when someone else is waiting.
      pick_mask   = (at_limit && others_pend) ? ~owner_oh : '1;
   end

   bram_port_arbiter_rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req_i  (req),
      .ptr_i  (ptr_q),
      .mask_i (pick_mask),
      .gnt_o  (pick_oh)
   );

   always_comb begin
      win_oh     = keep ? owner_oh : pick_oh;
      any_win    = |win_oh;
      win_idx    = '0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_idx    = IW'(i);
            mem_addr_d = addr[i*ADDR_W +: ADDR_W];
            mem_din_d  = wdata[i*DATA_W +: DATA_W];
            mem_we_d   = we[i];
         end
      end

      st_d      = any_win ? ST_OWN : ST_IDLE;
      cmd_idx_d = any_win ? win_idx : cmd_idx_q;
      ptr_d     = ptr_q;
      cnt_d     = '0;
      if (any_win) begin
         ptr_d = (win_idx == LAST) ? '0 : win_idx + ONE_I;
         if (keep) cnt_d = at_limit ? cnt_q : cnt_q + ONE_C;
         else      cnt_d = ONE_C;
      end
   end

   always_ff @(posedge clka or posedge reset) begin
      if (reset) begin
         st_q       <= ST_IDLE;
         cmd_idx_q  <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_idx_q   <= '0;
      end else begin
         st_q       <= st_d;
         cmd_idx_q  <= cmd_idx_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         rd_vld_q   <= (st_q == ST_OWN) && !mem_we_q;
         rd_idx_q   <= cmd_idx_q;
      end
   end

   assign gnt      = owner_oh;
   assign rvalid   = rd_vld_q ? (ONE_N << rd_idx_q) : '0;
   assign rdata    = mem_dout;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;

endmodule
